// File: rtl/wbuf_drain_ctl_pkg.sv
`default_nettype none
// ============================================================================
// Module  : wbuf_drain_ctl_pkg
// Brief   : Shared types for the write-buffer drain controller. The drain FSM
//           encoding matches the encoding used by the bus-side blocks.
// Revision: 1.0 - initial release
// ============================================================================
package wbuf_drain_ctl_pkg;

  // Drain FSM states; encodings are shared with the bus-side logic.
  typedef enum logic [1:0] {
    ST_IDLE    = 2'b00,
    ST_REQ     = 2'b01,
    ST_BACKOFF = 2'b10
  } wbuf_state_e;

endpackage
`default_nettype wire

// File: rtl/wbuf_ffz.sv
`default_nettype none
// ============================================================================
// Module  : wbuf_ffz
// Brief   : Combinational find-first-zero. Returns a one-hot vector that marks
//           the lowest clear bit of i_vec. The result is all zero when i_vec is
//           all ones.
// Revision: 1.0 - initial release
// ============================================================================
module wbuf_ffz #(
  parameter int DEPTH = 4
) (
  input  logic [DEPTH-1:0] i_vec,
  output logic [DEPTH-1:0] o_onehot
);

  localparam logic [DEPTH-1:0] c_ONE = {{(DEPTH-1){1'b0}}, 1'b1};

  // Adding one carries through the trailing ones and sets the first zero.
  // Masking with ~i_vec keeps only that newly set bit.
  always_comb begin
    o_onehot = ~i_vec & (i_vec + c_ONE);
  end

endmodule
`default_nettype wire

// File: rtl/wbuf_drain_ctl.sv
`default_nettype none
// ============================================================================
// Module  : wbuf_drain_ctl
// Brief   : Control and drain end of the write-buffer FIFO. It tracks the
//           valid bits, drives the datapath load and shift controls, and pops
//           the head entry onto the local bus with a req/ack/retry handshake.
//           It also qualifies raw compare hits for hazard detection.
// Revision: 1.0 - initial release
// ============================================================================
module wbuf_drain_ctl
  import wbuf_drain_ctl_pkg::*;
#(
  parameter int DEPTH     = 4,
  parameter int WIDTH     = 32,
  parameter int RETRY_DLY = 3,
  parameter int RCNT_W    = 2
) (
  input  logic             CLOCKI,
  input  logic             RESET_D1_R_N,
  input  logic             PUSHI,
  output logic             PUSH_ACKO,
  output logic             FULLO,
  output logic             EMPTYO,
  output logic [DEPTH-1:0] VALIDO,
  output logic             SHIFTO,
  input  logic [WIDTH-1:0] HEADI,
  input  logic [DEPTH-1:0] HITI,
  output logic             HITANYO,
  output logic             BREQO,
  output logic [WIDTH-1:0] BDATAO,
  input  logic             BACKI,
  input  logic             BRETRYI,
  input  logic             BERRI,
  output logic             ERRO,
  input  logic             FLUSHI,
  output logic             FLUSH_DONEO
);

  localparam logic [RCNT_W-1:0] c_RETRY_DLY = RCNT_W'(RETRY_DLY);
  localparam logic [RCNT_W-1:0] c_CNT_ONE   = RCNT_W'(1);

  wbuf_state_e       r_state;
  wbuf_state_e       w_state_nxt;
  logic [RCNT_W-1:0] r_cnt;
  logic [RCNT_W-1:0] w_cnt_nxt;
  logic [DEPTH-1:0]  r_valid;
  logic [DEPTH-1:0]  w_valid_nxt;
  logic [DEPTH-1:0]  w_valid_shf;
  logic [DEPTH-1:0]  w_slot;
  logic              r_err;
  logic              w_err_set;
  logic              w_shift;
  logic              w_breq;
  logic              w_push_ack;

  // Slot for an incoming push is the lowest empty entry after any pop.
  wbuf_ffz #(
    .DEPTH (DEPTH)
  ) u_ffz (
    .i_vec    (w_valid_shf),
    .o_onehot (w_slot)
  );

  // A push while full is refused even during a pop: the datapath holds its
  // last slot whenever that slot is valid.
  always_comb begin
    w_push_ack  = PUSHI & ~r_valid[DEPTH-1];
    w_valid_shf = w_shift ? {1'b0, r_valid[DEPTH-1:1]} : r_valid;
    w_valid_nxt = w_valid_shf | (w_push_ack ? w_slot : '0);
  end

  // Next-state and handshake decode; bus responses are only honoured in REQ.
  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_shift     = 1'b0;
    w_breq      = 1'b0;
    w_err_set   = 1'b0;
    unique case (r_state)
      ST_IDLE: begin
        if (r_valid[0]) w_state_nxt = ST_REQ;
      end
      ST_REQ: begin
        w_breq = 1'b1;
        if (BERRI) begin
          w_shift     = 1'b1;
          w_err_set   = 1'b1;
          w_state_nxt = ST_IDLE;
        end else if (BACKI) begin
          w_shift     = 1'b1;
          w_state_nxt = r_valid[1] ? ST_REQ : ST_IDLE;
        end else if (BRETRYI) begin
          w_cnt_nxt   = c_RETRY_DLY;
          w_state_nxt = ST_BACKOFF;
        end
      end
      ST_BACKOFF: begin
        w_cnt_nxt = r_cnt - c_CNT_ONE;
        if (r_cnt == c_CNT_ONE) w_state_nxt = ST_REQ;
      end
      default: begin
        w_state_nxt = ST_IDLE;
      end
    endcase
  end

  // State, back-off counter, valid vector and error pulse registers.
  always_ff @(posedge CLOCKI) begin
    if (!RESET_D1_R_N) begin
      r_state <= ST_IDLE;
      r_cnt   <= '0;
      r_valid <= '0;
      r_err   <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
      r_valid <= w_valid_nxt;
      r_err   <= w_err_set;
    end
  end

  // Output mapping; bus data is forced to zero while no request is up.
  always_comb begin
    PUSH_ACKO   = w_push_ack;
    FULLO       = r_valid[DEPTH-1];
    EMPTYO      = ~r_valid[0];
    VALIDO      = r_valid;
    SHIFTO      = w_shift;
    HITANYO     = |(HITI & r_valid);
    BREQO       = w_breq;
    BDATAO      = w_breq ? HEADI : '0;
    ERRO        = r_err;
    FLUSH_DONEO = FLUSHI & ~r_valid[0] & (r_state == ST_IDLE);
  end

endmodule
`default_nettype wire

// File: tb/tb_wbuf_drain_ctl.sv
`default_nettype none
// ============================================================================
// Module  : tb_wbuf_drain_ctl
// Brief   : Self-checking bench for wbuf_drain_ctl with a behavioural datapath
//           model and a bus-entry scoreboard.
// Revision: 1.0 - initial release
// ============================================================================
module tb_wbuf_drain_ctl;

  localparam int DEPTH = 4;
  localparam int WIDTH = 32;

  logic             clk = 1'b0;
  logic             rst_n;
  logic             pushi, push_acko, fullo, emptyo, shifto, hitanyo;
  logic             breqo, backi, bretryi, berri, erro, flushi, flush_doneo;
  logic [DEPTH-1:0] valido, hiti;
  logic [WIDTH-1:0] headi, bdatao, datai;

  int tests = 0;
  int fails = 0;

  logic [WIDTH-1:0] sb[$];
  logic [WIDTH-1:0] dp[$];

  wbuf_drain_ctl #(
    .DEPTH(DEPTH), .WIDTH(WIDTH), .RETRY_DLY(3), .RCNT_W(2)
  ) dut (
    .CLOCKI(clk), .RESET_D1_R_N(rst_n), .PUSHI(pushi), .PUSH_ACKO(push_acko),
    .FULLO(fullo), .EMPTYO(emptyo), .VALIDO(valido), .SHIFTO(shifto),
    .HEADI(headi), .HITI(hiti), .HITANYO(hitanyo), .BREQO(breqo),
    .BDATAO(bdatao), .BACKI(backi), .BRETRYI(bretryi), .BERRI(berri),
    .ERRO(erro), .FLUSHI(flushi), .FLUSH_DONEO(flush_doneo)
  );

  always #5 clk = ~clk;

  // Behavioural datapath: shifts on pop, appends on accepted push.
  always @(posedge clk) begin
    if (!rst_n) begin
      dp.delete();
    end else begin
      if (shifto && dp.size() > 0) void'(dp.pop_front());
      if (push_acko) dp.push_back(datai);
    end
    headi = (dp.size() > 0) ? dp[0] : '0;
  end

  // Monitor: every entry leaving on the bus (ack or error) must be the next expected one.
  always @(negedge clk) begin
    if (rst_n && breqo && (backi || berri)) begin
      tests++;
      if (sb.size() == 0) begin
        fails++;
        $display("FAIL bus_entry: got %h, required no entry", bdatao);
      end else begin
        logic [WIDTH-1:0] exp_d;
        exp_d = sb.pop_front();
        if (bdatao !== exp_d) begin
          fails++;
          $display("FAIL bus_entry: got %h, required %h", bdatao, exp_d);
        end
      end
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp_v);
    tests++;
    if (act !== exp_v) begin
      fails++;
      $display("FAIL %s: got %h, required %h", name, act, exp_v);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic samp();
    @(negedge clk);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1, "timeout");
  end

  initial begin
    rst_n = 1'b0; pushi = 1'b0; datai = '0; hiti = '0;
    backi = 1'b0; bretryi = 1'b0; berri = 1'b0; flushi = 1'b0;
    headi = '0;
    step(); step();

    // Reset state
    samp();
    check("rst_valid", 32'(valido), 32'h0);
    check("rst_breq", 32'(breqo), 32'h0);
    check("rst_empty", 32'(emptyo), 32'h1);
    check("rst_full", 32'(fullo), 32'h0);
    check("rst_bdata", bdatao, 32'h0);
    check("rst_err", 32'(erro), 32'h0);
    check("rst_shift", 32'(shifto), 32'h0);
    step();

    // Three pushes; request appears two cycles after the first push
    rst_n = 1'b1; pushi = 1'b1; datai = 32'hA000_0000;
    samp(); check("push0_ack", 32'(push_acko), 32'h1); sb.push_back(datai);
    step();
    datai = 32'hA000_0001;
    samp(); check("push1_breq_lat", 32'(breqo), 32'h0); sb.push_back(datai);
    step();
    datai = 32'hA000_0002;
    samp(); check("push2_breq", 32'(breqo), 32'h1); sb.push_back(datai);
    step();
    pushi = 1'b0;
    for (int i = 0; i < 3; i++) begin
      samp();
      check("hold_valid", 32'(valido), 32'h7);
      check("hold_breq", 32'(breqo), 32'h1);
      check("hold_bdata", bdatao, 32'hA000_0000);
      step();
    end

    // Fill to four, then a rejected push while full
    pushi = 1'b1; datai = 32'hA000_0003;
    samp(); check("push3_ack", 32'(push_acko), 32'h1); sb.push_back(datai);
    step();
    datai = 32'hA000_0004;
    samp();
    check("full_flag", 32'(fullo), 32'h1);
    check("full_noack", 32'(push_acko), 32'h0);
    check("full_valid", 32'(valido), 32'hF);
    step();
    backi = 1'b1;
    samp();
    check("full_pop_noack", 32'(push_acko), 32'h0);
    check("ack_shift", 32'(shifto), 32'h1);
    step();
    pushi = 1'b0; backi = 1'b0;
    samp();
    check("after_pop_valid", 32'(valido), 32'h7);
    check("b2b_bdata", bdatao, 32'hA000_0001);
    step();
    backi = 1'b1;
    samp();
    step();
    // Push and pop together at count two
    pushi = 1'b1; datai = 32'hA000_0005;
    samp();
    check("pp_valid_before", 32'(valido), 32'h3);
    check("pp_ack", 32'(push_acko), 32'h1); sb.push_back(datai);
    step();
    pushi = 1'b0; backi = 1'b0;
    samp();
    check("pp_valid_after", 32'(valido), 32'h3);
    check("pp_bdata", bdatao, 32'hA000_0003);
    step();

    // Retry back-off: request low for exactly three cycles
    bretryi = 1'b1;
    samp(); check("retry_breq", 32'(breqo), 32'h1);
    step();
    bretryi = 1'b0;
    for (int i = 0; i < 3; i++) begin
      samp(); check("backoff_breq", 32'(breqo), 32'h0);
      step();
    end
    samp();
    check("rereq_breq", 32'(breqo), 32'h1);
    check("rereq_bdata", bdatao, 32'hA000_0003);
    step();

    // Bus error drops the head entry and pulses ERRO once
    berri = 1'b1;
    samp();
    check("berr_shift", 32'(shifto), 32'h1);
    check("berr_erro_pre", 32'(erro), 32'h0);
    step();
    berri = 1'b0;
    samp();
    check("berr_erro", 32'(erro), 32'h1);
    check("berr_valid", 32'(valido), 32'h1);
    check("berr_idle_breq", 32'(breqo), 32'h0);
    step();
    samp();
    check("berr_erro_once", 32'(erro), 32'h0);
    check("berr_next_bdata", bdatao, 32'hA000_0005);
    step();

    // Hit qualification
    pushi = 1'b1; datai = 32'hA000_0006;
    samp(); check("push6_ack", 32'(push_acko), 32'h1); sb.push_back(datai);
    step();
    pushi = 1'b0; hiti = 4'b1110;
    samp();
    check("hit_valid", 32'(valido), 32'h3);
    check("hit_any1", 32'(hitanyo), 32'h1);
    step();
    hiti = 4'b1100;
    samp(); check("hit_any0", 32'(hitanyo), 32'h0);
    step();
    hiti = '0;

    // Reset in REQ with two pending entries
    rst_n = 1'b0;
    samp(); check("rst_mid_breq_pre", 32'(breqo), 32'h1);
    sb.delete();
    step();
    rst_n = 1'b1;
    samp();
    check("rst_mid_breq", 32'(breqo), 32'h0);
    check("rst_mid_empty", 32'(emptyo), 32'h1);
    check("rst_mid_valid", 32'(valido), 32'h0);
    step();

    // Flush done only once empty and idle
    flushi = 1'b1;
    samp(); check("flush_done_empty", 32'(flush_doneo), 32'h1);
    step();
    pushi = 1'b1; datai = 32'hA000_0007;
    samp(); sb.push_back(datai);
    step();
    pushi = 1'b0;
    samp(); check("flush_busy", 32'(flush_doneo), 32'h0);
    step();
    backi = 1'b1;
    samp(); check("flush_req", 32'(flush_doneo), 32'h0);
    step();
    backi = 1'b0;
    samp();
    check("flush_done", 32'(flush_doneo), 32'h1);
    check("flush_empty", 32'(emptyo), 32'h1);
    check("sb_drained", 32'(sb.size()), 32'h0);
    step();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
`default_nettype wire
